// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops the CDB, issues the lowest ready entry.
// Optional build macro RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match count toward readiness.
module alu_rs #(
    parameter int unsigned RS_SIZE  = 8,
    parameter int unsigned RS_IDX_W = 3,
    parameter int unsigned ROB_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             disp_valid,
    input  logic [5:0]       disp_opcode_id,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [31:0]      disp_A,
    input  logic [ROB_W-1:0] disp_rob_pos,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_pos,
    input  logic [31:0]      cdb_val,
    output logic             instr_valid,
    output logic [5:0]       opcode_id,
    output logic [31:0]      vj,
    output logic [31:0]      vk,
    output logic [31:0]      A,
    output logic [ROB_W-1:0] ROB_pos
);

    logic [RS_SIZE-1:0] busy_q, busy_d, qj_busy_q, qj_busy_d, qk_busy_q, qk_busy_d;
    logic [5:0]         op_q  [RS_SIZE];
    logic [5:0]         op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [31:0]        a_q   [RS_SIZE];
    logic [31:0]        a_d   [RS_SIZE];
    logic [ROB_W-1:0]   qj_q  [RS_SIZE];
    logic [ROB_W-1:0]   qj_d  [RS_SIZE];
    logic [ROB_W-1:0]   qk_q  [RS_SIZE];
    logic [ROB_W-1:0]   qk_d  [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE];
    logic [ROB_W-1:0]   rob_d [RS_SIZE];

    logic [RS_SIZE-1:0]  wake_j, wake_k, ready;
    logic [RS_IDX_W-1:0] free_idx, sel_idx;
    logic                sel_found;
    logic                cap_j, cap_k;

    logic             iv_d;
    logic [5:0]       op_out_d;
    logic [31:0]      vj_out_d, vk_out_d, a_out_d;
    logic [ROB_W-1:0] rob_out_d;

    assign rs_full = &busy_q;
    assign cap_j   = cdb_valid && disp_qj_busy && (cdb_rob_pos == disp_qj);
    assign cap_k   = cdb_valid && disp_qk_busy && (cdb_rob_pos == disp_qk);

    always_comb begin
        wake_j    = '0;
        wake_k    = '0;
        ready     = '0;
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j[i] = busy_q[i] && qj_busy_q[i] && cdb_valid && (qj_q[i] == cdb_rob_pos);
            wake_k[i] = busy_q[i] && qk_busy_q[i] && cdb_valid && (qk_q[i] == cdb_rob_pos);
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i]  = busy_q[i] && (!qj_busy_q[i] || wake_j[i]) && (!qk_busy_q[i] || wake_k[i]);
`else
            ready[i]  = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
        end
        // Scan downward so the lowest index wins.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = RS_IDX_W'(i);
            if (ready[i]) begin
                sel_idx   = RS_IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        a_d       = a_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        rob_d     = rob_q;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (wake_j[i]) begin
                vj_d[i]      = cdb_val;
                qj_busy_d[i] = 1'b0;
            end
            if (wake_k[i]) begin
                vk_d[i]      = cdb_val;
                qk_busy_d[i] = 1'b0;
            end
        end

        if (sel_found) busy_d[sel_idx] = 1'b0;

        // Free slot was idle this cycle, so it can never collide with the issuing entry.
        if (disp_valid && !rs_full) begin
            busy_d[free_idx]    = 1'b1;
            op_d[free_idx]      = disp_opcode_id;
            a_d[free_idx]       = disp_A;
            rob_d[free_idx]     = disp_rob_pos;
            qj_d[free_idx]      = disp_qj;
            qk_d[free_idx]      = disp_qk;
            vj_d[free_idx]      = cap_j ? cdb_val : disp_vj;
            vk_d[free_idx]      = cap_k ? cdb_val : disp_vk;
            qj_busy_d[free_idx] = disp_qj_busy && !cap_j;
            qk_busy_d[free_idx] = disp_qk_busy && !cap_k;
        end

        if (clear) busy_d = '0;
    end

    always_comb begin
        iv_d      = 1'b0;
        op_out_d  = opcode_id;
        vj_out_d  = vj;
        vk_out_d  = vk;
        a_out_d   = A;
        rob_out_d = ROB_pos;
        if (sel_found && !clear) begin
            iv_d      = 1'b1;
            op_out_d  = op_q[sel_idx];
            // Wake flags can only be set on a selected entry in the bypass build.
            vj_out_d  = wake_j[sel_idx] ? cdb_val : vj_q[sel_idx];
            vk_out_d  = wake_k[sel_idx] ? cdb_val : vk_q[sel_idx];
            a_out_d   = a_q[sel_idx];
            rob_out_d = rob_q[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            qj_busy_q   <= '0;
            qk_busy_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                a_q[i]   <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            instr_valid <= 1'b0;
            opcode_id   <= '0;
            vj          <= '0;
            vk          <= '0;
            A           <= '0;
            ROB_pos     <= '0;
        end else if (rdy) begin
            busy_q      <= busy_d;
            qj_busy_q   <= qj_busy_d;
            qk_busy_q   <= qk_busy_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            a_q         <= a_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            rob_q       <= rob_d;
            instr_valid <= iv_d;
            opcode_id   <= op_out_d;
            vj          <= vj_out_d;
            vk          <= vk_out_d;
            A           <= a_out_d;
            ROB_pos     <= rob_out_d;
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a behavioural entry-table model predicts every cycle's ALU output.
module tb_alu_rs;
    localparam int RS = 8;
    localparam int RW = 4;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;

    logic clk = 1'b0;
    logic rst, rdy, clear, disp_valid, disp_qj_busy, disp_qk_busy, rs_full;
    logic [5:0] disp_opcode_id, opcode_id;
    logic [31:0] disp_vj, disp_vk, disp_A, cdb_val, vj, vk, A;
    logic [RW-1:0] disp_qj, disp_qk, disp_rob_pos, cdb_rob_pos, ROB_pos;
    logic cdb_valid, instr_valid;

    alu_rs #(.RS_SIZE(RS), .RS_IDX_W(3), .ROB_W(RW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .disp_valid(disp_valid), .disp_opcode_id(disp_opcode_id),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy), .disp_A(disp_A),
        .disp_rob_pos(disp_rob_pos), .rs_full(rs_full), .cdb_valid(cdb_valid),
        .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .instr_valid(instr_valid),
        .opcode_id(opcode_id), .vj(vj), .vk(vk), .A(A), .ROB_pos(ROB_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic busy; logic [5:0] op; logic [31:0] vj, vk, a;
        logic [RW-1:0] qj, qk, rob; logic qjb, qkb;
    } ent_t;
    typedef struct {
        logic iv; logic [5:0] op; logic [31:0] vj, vk, a; logic [RW-1:0] rob;
    } out_t;

    ent_t m [RS];
    out_t mo;
    out_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < RS; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the station as described in words: flush, pick, wake, free, fill.
    task automatic model_step();
        bit full;
        int fidx, sidx;
        if (!rdy) return;
        full = model_full();
        if (clear) begin
            for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
            mo.iv = 1'b0;
            return;
        end
        fidx = -1;
        sidx = -1;
        for (int i = RS - 1; i >= 0; i--) begin
            bit mj, mk;
            mj = cdb_valid && m[i].qjb && m[i].qj == cdb_rob_pos;
            mk = cdb_valid && m[i].qkb && m[i].qk == cdb_rob_pos;
            if (!m[i].busy) fidx = i;
            if (m[i].busy && (!m[i].qjb || (BYP && mj)) && (!m[i].qkb || (BYP && mk))) sidx = i;
        end
        mo.iv = (sidx >= 0);
        if (sidx >= 0) begin
            mo.op  = m[sidx].op;
            mo.vj  = m[sidx].qjb ? cdb_val : m[sidx].vj;
            mo.vk  = m[sidx].qkb ? cdb_val : m[sidx].vk;
            mo.a   = m[sidx].a;
            mo.rob = m[sidx].rob;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy && cdb_valid && m[i].qjb && m[i].qj == cdb_rob_pos) begin
                m[i].vj = cdb_val; m[i].qjb = 1'b0;
            end
            if (m[i].busy && cdb_valid && m[i].qkb && m[i].qk == cdb_rob_pos) begin
                m[i].vk = cdb_val; m[i].qkb = 1'b0;
            end
        end
        if (sidx >= 0) m[sidx].busy = 1'b0;
        if (disp_valid && !full) begin
            bit cj, ck;
            cj = cdb_valid && disp_qj_busy && cdb_rob_pos == disp_qj;
            ck = cdb_valid && disp_qk_busy && cdb_rob_pos == disp_qk;
            m[fidx].busy = 1'b1;
            m[fidx].op   = disp_opcode_id;
            m[fidx].a    = disp_A;
            m[fidx].rob  = disp_rob_pos;
            m[fidx].qj   = disp_qj;
            m[fidx].qk   = disp_qk;
            m[fidx].vj   = cj ? cdb_val : disp_vj;
            m[fidx].vk   = ck ? cdb_val : disp_vk;
            m[fidx].qjb  = disp_qj_busy && !cj;
            m[fidx].qkb  = disp_qk_busy && !ck;
        end
    endtask

    task automatic step();
        chk("rs_full", rs_full, model_full());
        model_step();
        @(posedge clk);
        #1;
        sbq.push_back(mo);
    endtask

    task automatic idle();
        rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] a_vj, input logic [31:0] a_vk,
                            input logic [RW-1:0] qj, input logic qjb, input logic [RW-1:0] qk,
                            input logic qkb, input logic [31:0] imm, input logic [RW-1:0] rob);
        disp_valid = 1'b1; disp_opcode_id = op; disp_vj = a_vj; disp_vk = a_vk;
        disp_qj = qj; disp_qj_busy = qjb; disp_qk = qk; disp_qk_busy = qkb;
        disp_A = imm; disp_rob_pos = rob;
    endtask

    task automatic set_cdb(input logic [RW-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_rob_pos = tag; cdb_val = val;
    endtask

    always @(negedge clk) begin
        if (rst && sbq.size() != 0) begin
            out_t e;
            e = sbq.pop_front();
            chk("instr_valid", instr_valid, e.iv);
            chk("opcode_id", opcode_id, e.op);
            chk("vj", vj, e.vj);
            chk("vk", vk, e.vk);
            chk("A", A, e.a);
            chk("ROB_pos", ROB_pos, e.rob);
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        cdb_rob_pos = '0; cdb_val = '0;
        set_disp(OP_ADD, 32'd1, 32'd2, '0, 1'b0, '0, 1'b0, 32'd0, 4'd1);
        for (int i = 0; i < RS; i++) m[i] = '{default: '0};
        mo = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_instr_valid", instr_valid, 1'b0);
            chk("reset_rs_full", rs_full, 1'b0);
        end
        idle();
        rst = 1'b1;
        step(); step();

        set_disp(OP_ADD, 32'd5, 32'd7, '0, 1'b0, '0, 1'b0, 32'd0, 4'd3);
        step();
        idle();
        step(); step();
        chk("add_drops", instr_valid, 1'b0);

        set_disp(OP_ADDI, 32'd0, 32'd0, 4'd6, 1'b1, '0, 1'b0, 32'd10, 4'd4);
        step();
        idle(); step();
        set_cdb(4'd6, 32'h20); step();
        idle(); step(); step(); step();

        set_disp(OP_ADD, 32'd1, 32'd0, '0, 1'b0, 4'd2, 1'b1, 32'd0, 4'd5);
        set_cdb(4'd2, 32'hFFFF_FFFF);
        step();
        idle(); step(); step();

        for (int i = 0; i < RS; i++) begin
            set_disp(OP_ADD, 32'd0, 32'(i * 3), 4'd1, 1'b1, '0, 1'b0, 32'(i), 4'(i + 8));
            step();
        end
        idle();
        chk("full_after_fill", rs_full, 1'b1);
        set_disp(OP_ADDI, 32'd9, 32'd9, '0, 1'b0, '0, 1'b0, 32'd99, 4'd15);
        step();
        idle(); set_cdb(4'd1, 32'h1234_5678); step();
        idle();
        for (int i = 0; i < 10; i++) step();

        for (int i = 0; i < 4; i++) begin
            set_disp(OP_ADD, 32'(i), 32'd0, 4'd9, 1'b1, '0, 1'b0, 32'd0, 4'(i));
            step();
        end
        idle(); rdy = 1'b0; set_cdb(4'd9, 32'hDEAD); step(); step();
        idle(); clear = 1'b1; step();
        idle(); chk("flush_full", rs_full, 1'b0);
        set_cdb(4'd9, 32'hBEEF); step();
        idle(); step(); step(); step();

        for (int n = 0; n < 600; n++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 49) == 0);
            disp_valid = $urandom_range(0, 1);
            disp_opcode_id = 6'($urandom);
            disp_vj = $urandom; disp_vk = $urandom; disp_A = $urandom;
            disp_qj = 4'($urandom_range(0, 3)); disp_qk = 4'($urandom_range(0, 3));
            disp_qj_busy = ($urandom_range(0, 2) == 0);
            disp_qk_busy = ($urandom_range(0, 2) == 0);
            disp_rob_pos = 4'($urandom);
            cdb_valid = $urandom_range(0, 1);
            cdb_rob_pos = 4'($urandom_range(0, 3));
            cdb_val = $urandom;
            step();
        end
        idle();
        for (int i = 0; i < 12; i++) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
